// File: rtl/display_scan_blink.sv
// Multiplexed seven-segment driver: scans NUM_DIGITS BCD/hex digits onto shared
// segment lines, with field blinking, leading-zero blanking and selectable polarity.
module display_scan_blink #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 100000,
    parameter int BLINK_DIV      = 25000000,
    parameter int FIELD_W        = 2,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int HEX_EN         = 0
) (
    input  logic                    clk_100MHz,
    input  logic                    rst_time,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    blink_en,
    input  logic [FIELD_W-1:0]      blink_field,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   bit_sel,
    output logic [6:0]              seg_sel
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    logic [SCAN_W-1:0]     scan_cnt;
    logic [BLINK_W-1:0]    blink_cnt;
    logic [IDX_W-1:0]      idx;
    logic                  blink_phase;

    logic [3:0]            val_p0;
    logic                  blank_p0;
    logic [6:0]            seg_p0;
    logic [NUM_DIGITS-1:0] sel_p0;

    // Active-high segment pattern, g..a; hex letters are suppressed by blank_p0 when HEX_EN=0.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h77;
            4'hB:    return 7'h7C;
            4'hC:    return 7'h39;
            4'hD:    return 7'h5E;
            4'hE:    return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    function automatic logic [6:0] seg_polarity(input logic [6:0] v);
        return (SEG_ACTIVE_LOW != 0) ? ~v : v;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] sel_polarity(input logic [NUM_DIGITS-1:0] v);
        return (SEL_ACTIVE_LOW != 0) ? ~v : v;
    endfunction

    always_comb begin
        val_p0   = digits[{idx, 2'b00} +: 4];
        blank_p0 = 1'b0;
        // Out-of-range blink_field values never match idx>>1, so nothing blinks.
        if (blink_en && (32'(blink_field) == (32'(idx) >> 1)) && blink_phase)
            blank_p0 = 1'b1;
        if (lz_blank && (idx == IDX_W'(NUM_DIGITS - 1)) && (val_p0 == 4'd0))
            blank_p0 = 1'b1;
        if ((HEX_EN == 0) && (val_p0 > 4'd9))
            blank_p0 = 1'b1;
        seg_p0      = blank_p0 ? 7'h00 : seg_decode(val_p0);
        sel_p0      = '0;
        sel_p0[idx] = 1'b1;
    end

    // p0 -> registered outputs; counters advance on the same edge.
    always_ff @(posedge clk_100MHz) begin
        if (rst_time) begin
            scan_cnt    <= '0;
            blink_cnt   <= '0;
            idx         <= '0;
            blink_phase <= 1'b0;
            bit_sel     <= sel_polarity('0);
            seg_sel     <= seg_polarity(7'h00);
        end else begin
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            bit_sel <= sel_polarity(sel_p0);
            seg_sel <= seg_polarity(seg_p0);
        end
    end

endmodule

// File: tb/tb_display_scan_blink.sv
// Bench for display_scan_blink: two instances (active-low/no-hex and active-high/hex)
// share stimulus and are checked every cycle against a time-based reference model.
module tb_display_scan_blink;

    localparam int N     = 6;
    localparam int SCAN  = 4;
    localparam int BLINK = 16;

    logic          clk_100MHz;
    logic          rst_time;
    logic [4*N-1:0] digits;
    logic          blink_en;
    logic [1:0]    blink_field;
    logic          lz_blank;
    logic [N-1:0]  bit_sel_a, bit_sel_b;
    logic [6:0]    seg_sel_a, seg_sel_b;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;   // edges since reset release

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    display_scan_blink #(
        .NUM_DIGITS(N), .SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .FIELD_W(2),
        .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1), .HEX_EN(0)
    ) dut_a (
        .clk_100MHz(clk_100MHz), .rst_time(rst_time), .digits(digits),
        .blink_en(blink_en), .blink_field(blink_field), .lz_blank(lz_blank),
        .bit_sel(bit_sel_a), .seg_sel(seg_sel_a)
    );

    display_scan_blink #(
        .NUM_DIGITS(N), .SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .FIELD_W(2),
        .SEL_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0), .HEX_EN(1)
    ) dut_b (
        .clk_100MHz(clk_100MHz), .rst_time(rst_time), .digits(digits),
        .blink_en(blink_en), .blink_field(blink_field), .lz_blank(lz_blank),
        .bit_sel(bit_sel_b), .seg_sel(seg_sel_b)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (k=%0d): got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    // Digit shown after edge k is the one scanned at time k; blink phase flips every BLINK edges.
    function automatic logic [6:0] exp_seg(input int kk, input bit hex, input bit seg_low);
        int d;
        int ph;
        int v;
        bit blank;
        logic [6:0] s;
        d     = (kk / SCAN) % N;
        ph    = (kk / BLINK) % 2;
        v     = int'((digits >> (4 * d)) & 24'hF);
        blank = (blink_en && int'(blink_field) == d / 2 && ph == 1) ||
                (lz_blank && d == N - 1 && v == 0) ||
                (v > 9 && !hex);
        s     = blank ? 7'h00 : seg_tab[v];
        return seg_low ? ~s : s;
    endfunction

    function automatic logic [N-1:0] exp_sel(input int kk, input bit sel_low);
        logic [N-1:0] s;
        s = '0;
        s[(kk / SCAN) % N] = 1'b1;
        return sel_low ? ~s : s;
    endfunction

    task automatic step();
        @(posedge clk_100MHz);
        #1;
        if (rst_time) begin
            chk("rst_sel_a", 32'(bit_sel_a), 32'h3F);
            chk("rst_seg_a", 32'(seg_sel_a), 32'h7F);
            chk("rst_sel_b", 32'(bit_sel_b), 32'h00);
            chk("rst_seg_b", 32'(seg_sel_b), 32'h00);
            k = 0;
        end else begin
            if (k == 0) chk("first_digit0", 32'(bit_sel_a), 32'h3E);
            chk("sel_a", 32'(bit_sel_a), 32'(exp_sel(k, 1'b1)));
            chk("seg_a", 32'(seg_sel_a), 32'(exp_seg(k, 1'b0, 1'b1)));
            chk("sel_b", 32'(bit_sel_b), 32'(exp_sel(k, 1'b0)));
            chk("seg_b", 32'(seg_sel_b), 32'(exp_seg(k, 1'b1, 1'b0)));
            k++;
        end
    endtask

    initial begin
        rst_time    = 1'b1;
        digits      = '0;
        blink_en    = 1'b0;
        blink_field = 2'd0;
        lz_blank    = 1'b0;
        repeat (3) step();

        rst_time = 1'b0;
        digits   = 24'h235958;
        repeat (48) step();

        blink_en    = 1'b1;
        blink_field = 2'd2;
        repeat (64) step();
        blink_field = 2'd3;
        repeat (32) step();

        blink_en = 1'b0;
        lz_blank = 1'b1;
        digits   = 24'h035958;
        repeat (48) step();
        digits   = 24'h135958;
        repeat (24) step();
        lz_blank = 1'b0;

        digits = 24'h2359B8;
        repeat (24) step();

        // Reset landing while idx=3 and blink phase=1 (k=61).
        blink_en    = 1'b1;
        blink_field = 2'd0;
        rst_time    = 1'b1;
        step();
        rst_time = 1'b0;
        for (int i = 0; i < 200 && k != 61; i++) step();
        chk("reach_k61", 32'(k), 32'd61);
        rst_time = 1'b1;
        step();
        step();
        rst_time = 1'b0;
        repeat (40) step();

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int j = 0; j < N; j++)
                    digits[4*j +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                blink_en    = 1'($urandom_range(0, 1));
                blink_field = 2'($urandom_range(0, 3));
                lz_blank    = 1'($urandom_range(0, 1));
            end
            rst_time = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
